my_memory_mmio: RTL and testbench

MY_MEMORY_MMIO -- requirements
Module: my_memory_mmio

---
 rtl/my_memory_mmio.sv | 124 ++++++++++++
 tb/tb_my_memory_mmio.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/my_memory_mmio.sv
// rtl/my_memory_mmio.sv - memory-mapped RAM, screen buffer and keyboard scancode FIFO

module mmio_word_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];
endmodule

module my_memory_mmio #(
    parameter int DATA_W    = 16,
    parameter int RAM_AW    = 14,
    parameter int SCREEN_AW = RAM_AW - 1,
    parameter int KBD_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic [RAM_AW:0]   addr,
    input  logic              load,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] kbd_scancode,
    input  logic              kbd_valid,
    output logic              kbd_ready
);
    localparam int AW = RAM_AW + 1;
    localparam int PW = $clog2(KBD_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [AW-1:0] KBD_DATA_ADDR = AW'((1 << RAM_AW) + (1 << SCREEN_AW));
    localparam logic [AW-1:0] KBD_STAT_ADDR = AW'((1 << RAM_AW) + (1 << SCREEN_AW) + 1);
    localparam logic [CW-1:0] KBD_FULL = CW'(KBD_DEPTH);

    logic              is_ram, is_scr, is_kdata, is_kstat;
    logic [DATA_W-1:0] ram_rdata, scr_rdata, stat_word;
    logic [DATA_W-1:0] kbd_mem [KBD_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              fifo_empty, push, pop, flush, ovf_set, ovf_clr;

    // Main RAM occupies the lower half, so its decode is just the top address bit.
    assign is_ram   = !addr[AW-1];
    assign is_scr   = addr[AW-1] && (addr < KBD_DATA_ADDR);
    assign is_kdata = (addr == KBD_DATA_ADDR);
    assign is_kstat = (addr == KBD_STAT_ADDR);

    mmio_word_ram #(.DATA_W(DATA_W), .ADDR_W(RAM_AW)) u_ram (
        .clk   (clk),
        .we    (load && is_ram),
        .addr  (addr[RAM_AW-1:0]),
        .wdata (in),
        .rdata (ram_rdata)
    );

    mmio_word_ram #(.DATA_W(DATA_W), .ADDR_W(SCREEN_AW)) u_screen (
        .clk   (clk),
        .we    (load && is_scr),
        .addr  (addr[SCREEN_AW-1:0]),
        .wdata (in),
        .rdata (scr_rdata)
    );

    // Ready depends only on the registered count (and reset), never on the CPU side.
    assign fifo_empty = (count == '0);
    assign kbd_ready  = !reset && (count != KBD_FULL);
    assign push       = kbd_valid && kbd_ready;
    assign pop        = load && is_kdata && !fifo_empty;
    assign flush      = load && is_kstat && in[0];
    assign ovf_clr    = load && is_kstat && in[DATA_W-1];
    assign ovf_set    = kbd_valid && !kbd_ready;

    always_ff @(posedge clk) begin
        if (push) kbd_mem[wr_ptr] <= kbd_scancode;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PW'(1);
                if (pop)  rd_ptr <= rd_ptr + PW'(1);
                if (push && !pop)      count <= count + CW'(1);
                else if (!push && pop) count <= count - CW'(1);
            end
            // A new overflow beats a simultaneous software clear so no loss goes unreported.
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_comb begin
        stat_word             = '0;
        stat_word[DATA_W-1]   = overflow;
        stat_word[CW-1:0]     = count;
    end

    always_comb begin
        out = '0;
        if (is_ram)        out = ram_rdata;
        else if (is_scr)   out = scr_rdata;
        else if (is_kdata) out = fifo_empty ? '0 : kbd_mem[rd_ptr];
        else if (is_kstat) out = stat_word;
    end
endmodule

// File: tb/tb_my_memory_mmio.sv
// tb/tb_my_memory_mmio.sv - scoreboard bench for my_memory_mmio

module tb_my_memory_mmio;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in = '0;
    logic [14:0] addr = '0;
    logic        load = 1'b0;
    logic [15:0] out;
    logic [15:0] kbd_scancode = '0;
    logic        kbd_valid = 1'b0;
    logic        kbd_ready;

    localparam logic [14:0] KD = 15'h6000;
    localparam logic [14:0] KS = 15'h6001;

    typedef struct {
        string       name;
        logic [15:0] exp;
        bit          is_ready;
    } sb_t;

    sb_t sb[$];
    bit  chk_req = 1'b0;
    int  n_chk = 0;
    int  n_fail = 0;

    my_memory_mmio dut (
        .clk          (clk),
        .reset        (reset),
        .in           (in),
        .addr         (addr),
        .load         (load),
        .out          (out),
        .kbd_scancode (kbd_scancode),
        .kbd_valid    (kbd_valid),
        .kbd_ready    (kbd_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (chk_req) begin
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: monitor saw a check with no expected entry");
            end else begin
                sb_t e;
                logic [15:0] act;
                e = sb.pop_front();
                n_chk++;
                act = e.is_ready ? {15'b0, kbd_ready} : out;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [15:0] exp, input bit is_ready);
        sb_t e;
        e.name = name; e.exp = exp; e.is_ready = is_ready;
        sb.push_back(e);
        chk_req = 1'b1;
        @(negedge clk);
        #1 chk_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [14:0] a, input logic [15:0] exp, input string name);
        addr = a;
        load = 1'b0;
        expect_now(name, exp, 1'b0);
    endtask

    task automatic chk_ready(input logic exp, input string name);
        expect_now(name, {15'b0, exp}, 1'b1);
    endtask

    task automatic wr(input logic [14:0] a, input logic [15:0] d);
        addr = a; in = d; load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
    endtask

    task automatic push(input logic [15:0] code);
        kbd_scancode = code; kbd_valid = 1'b1;
        @(posedge clk);
        #1 kbd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_ready(1'b0, "ready_in_reset");
        reset = 1'b0;
        chk_ready(1'b1, "ready_after_reset");
        rd(KS, 16'h0000, "stat_after_reset");
        rd(KD, 16'h0000, "data_after_reset");

        // memory map
        wr(15'h0005, 16'h1234);
        rd(15'h0005, 16'h1234, "ram_rw");
        wr(15'h4005, 16'hBEEF);
        rd(15'h4005, 16'hBEEF, "screen_rw");
        rd(15'h0005, 16'h1234, "ram_after_screen");
        wr(15'h6002, 16'hDEAD);
        rd(15'h6002, 16'h0000, "unmapped_read");
        rd(15'h0005, 16'h1234, "ram_after_unmapped");
        rd(15'h4005, 16'hBEEF, "screen_after_unmapped");
        rd(KS, 16'h0000, "stat_after_unmapped");

        // FIFO order
        push(16'h0041); push(16'h0042); push(16'h0043);
        rd(KS, 16'h0003, "order_count3");
        rd(KD, 16'h0041, "order_head41");
        wr(KD, 16'hFFFF);
        rd(KD, 16'h0042, "order_head42");
        wr(KD, 16'h0000); wr(KD, 16'h0000);
        rd(KS, 16'h0000, "order_empty_stat");
        rd(KD, 16'h0000, "order_empty_data");
        wr(KD, 16'h0000);
        rd(KS, 16'h0000, "pop_empty_stat");

        // full / overflow / wrap
        kbd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kbd_scancode = 16'h0051 + 16'(i);
            @(posedge clk);
            #1;
        end
        kbd_scancode = 16'h0055;
        chk_ready(1'b0, "ready_full");
        kbd_valid = 1'b0;
        rd(KS, 16'h8004, "stat_overflow");
        wr(KS, 16'h8000);
        rd(KS, 16'h0004, "stat_ovf_cleared");
        rd(KD, 16'h0051, "full_head51");
        wr(KD, 16'h0000); wr(KD, 16'h0000);
        push(16'h0056); push(16'h0057);
        rd(KS, 16'h0004, "wrap_count4");
        rd(KD, 16'h0053, "wrap_head53");
        wr(KD, 16'h0000);
        rd(KD, 16'h0054, "wrap_head54");
        wr(KD, 16'h0000);
        rd(KD, 16'h0056, "wrap_head56");
        wr(KD, 16'h0000);
        rd(KD, 16'h0057, "wrap_head57");
        wr(KD, 16'h0000);
        rd(KS, 16'h0000, "wrap_drained");

        // simultaneous push + pop
        push(16'h0061); push(16'h0062);
        kbd_scancode = 16'h0063; kbd_valid = 1'b1;
        wr(KD, 16'h0000);
        kbd_valid = 1'b0;
        rd(KS, 16'h0002, "pushpop_count");
        rd(KD, 16'h0062, "pushpop_head");
        wr(KS, 16'h0001);
        rd(KS, 16'h0000, "flush_stat");
        kbd_scancode = 16'h0071; kbd_valid = 1'b1;
        wr(KD, 16'h0000);
        kbd_valid = 1'b0;
        rd(KS, 16'h0001, "empty_pushpop_count");
        rd(KD, 16'h0071, "empty_pushpop_head");

        // flush beats push
        kbd_scancode = 16'h0081; kbd_valid = 1'b1;
        wr(KS, 16'h0001);
        kbd_valid = 1'b0;
        rd(KS, 16'h0000, "flush_vs_push_stat");
        rd(KD, 16'h0000, "flush_vs_push_data");

        // clear + flush together, then set beats clear
        for (int i = 0; i < 5; i++) push(16'h0090 + 16'(i));
        rd(KS, 16'h8004, "refill_overflow");
        wr(KS, 16'h8001);
        rd(KS, 16'h0000, "clear_and_flush");
        for (int i = 0; i < 4; i++) push(16'h00A0 + 16'(i));
        kbd_scancode = 16'h00AF; kbd_valid = 1'b1;
        wr(KS, 16'h8000);
        kbd_valid = 1'b0;
        rd(KS, 16'h8004, "set_beats_clear");

        // reset mid-operation
        wr(KD, 16'h0000);
        rd(KS, 16'h8003, "pre_reset_stat");
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_ready(1'b0, "ready_mid_reset");
        reset = 1'b0;
        chk_ready(1'b1, "ready_post_reset");
        rd(KS, 16'h0000, "stat_post_reset");
        rd(KD, 16'h0000, "data_post_reset");
        rd(15'h0005, 16'h1234, "ram_kept_over_reset");
        rd(15'h4005, 16'hBEEF, "screen_kept_over_reset");

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
